// File: rtl/approx_add_arbiter.sv
// Two-requester arbiter in front of one shared 8-bit adder that can run exact or
// lower-part-OR approximate addition; one transaction in flight, round-robin on contention.
module approx_add_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req0_approx,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic        req1_approx,
  output logic        req1_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [8:0]  res_sum,
  output logic        res_id,
  output logic        res_approx,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t      state;
  logic        ptr;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic        approx_q;
  logic        id_q;
  logic [15:0] op_count_q;

  logic        gnt_valid;
  logic        gnt_id;
  logic [8:0]  exact_sum;
  logic [8:0]  approx_sum;
  logic [5:0]  approx_hi;
  logic        approx_cin;

  // Grant is combinational so a requester sees ready in the same IDLE cycle it offers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = ptr;
      end else if (req0_valid) begin
        gnt_valid = 1'b1;
      end else if (req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_valid & ~gnt_id;
  assign req1_ready = gnt_valid &  gnt_id;

  // Approximate: bits 2:0 are OR-ed, a[2]&b[2] is injected as carry into the exact upper part.
  assign exact_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign approx_cin = a_q[2] & b_q[2];
  assign approx_hi  = {1'b0, a_q[7:3]} + {1'b0, b_q[7:3]} + {5'b0, approx_cin};
  assign approx_sum = {approx_hi, a_q[2:0] | b_q[2:0]};

  assign busy     = (state != IDLE);
  assign op_count = op_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      approx_q   <= 1'b0;
      id_q       <= 1'b0;
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_id     <= 1'b0;
      res_approx <= 1'b0;
      op_count_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            a_q      <= gnt_id ? req1_a : req0_a;
            b_q      <= gnt_id ? req1_b : req0_b;
            approx_q <= gnt_id ? req1_approx : req0_approx;
            id_q     <= gnt_id;
            ptr      <= ~gnt_id;
            state    <= CALC;
          end
        end
        CALC: begin
          res_sum    <= approx_q ? approx_sum : exact_sum;
          res_id     <= id_q;
          res_approx <= approx_q;
          res_valid  <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
            if (op_count_q != 16'hFFFF) op_count_q <= op_count_q + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Scoreboard bench for approx_add_arbiter: accepted requests push a model result,
// result handshakes pop and compare; directed sections cover latency, arbitration, backpressure, reset, saturation.
module tb_approx_add_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_approx, req0_ready;
  logic [7:0]  req0_a, req0_b;
  logic        req1_valid, req1_approx, req1_ready;
  logic [7:0]  req1_a, req1_b;
  logic        res_valid, res_ready;
  logic [8:0]  res_sum;
  logic        res_id, res_approx, busy;
  logic [15:0] op_count;

  typedef struct {
    logic       id;
    logic       approx;
    logic [8:0] sum;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  approx_add_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_approx(req0_approx), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_approx(req1_approx), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_id(res_id), .res_approx(res_approx), .busy(busy), .op_count(op_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic ap);
    logic [8:0] s;
    logic       c;
    if (!ap) return {1'b0, a} + {1'b0, b};
    s[0] = a[0] | b[0];
    s[1] = a[1] | b[1];
    s[2] = a[2] | b[2];
    c    = a[2] & b[2];
    for (int i = 3; i < 8; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    s[8] = c;
    return s;
  endfunction

  // Scoreboard: push on request handshake, pop on result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (req0_ready && req1_ready) check("ready_excl", 32'd1, 32'd0);
      if (req0_valid && req0_ready) begin
        e.id = 1'b0; e.approx = req0_approx; e.sum = model(req0_a, req0_b, req0_approx);
        sb.push_back(e);
      end
      if (req1_valid && req1_ready) begin
        e.id = 1'b1; e.approx = req1_approx; e.sum = model(req1_a, req1_b, req1_approx);
        sb.push_back(e);
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("res_sum", 32'(res_sum), 32'(e.sum));
          check("res_id", 32'(res_id), 32'(e.id));
          check("res_approx", 32'(res_approx), 32'(e.approx));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic ap);
    if (r == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_approx = ap;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_approx = ap;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Offers one request on requester r with res_ready high; checks the 2-cycle latency.
  task automatic do_req(input int r, input logic [7:0] a, input logic [7:0] b, input logic ap);
    int n = 0;
    logic rdy;
    set_req(r, 1'b1, a, b, ap);
    do begin
      @(negedge clk);
      rdy = (r == 0) ? req0_ready : req1_ready;
      n++;
    end while (!rdy && n < 20);
    if (!rdy) begin
      check("req_timeout", 32'(rdy), 32'd1);
      set_req(r, 1'b0, a, b, ap);
      return;
    end
    tick();
    set_req(r, 1'b0, a, b, ap);
    check("lat_n1_valid", 32'(res_valid), 32'd0);
    check("lat_n1_busy", 32'(busy), 32'd1);
    tick();
    check("lat_n2_valid", 32'(res_valid), 32'd1);
    tick();
  endtask

  initial begin
    int   n;
    logic g;
    logic [15:0] cnt;
    rst = 1'b1; res_ready = 1'b1;
    set_req(0, 1'b1, 8'h00, 8'h00, 1'b0);
    set_req(1, 1'b1, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("rst_readies", {req0_ready, req1_ready}, 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_sum", 32'(res_sum), 32'd0);
    check("rst_res_id", {res_id, res_approx}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rst = 1'b0;

    // Approximate/exact pair, carry insertion, top carry.
    do_req(0, 8'h07, 8'h01, 1'b1);
    do_req(0, 8'h07, 8'h01, 1'b0);
    do_req(0, 8'h04, 8'h04, 1'b1);
    do_req(0, 8'hFF, 8'h01, 1'b1);
    do_req(1, 8'hFF, 8'h01, 1'b0);
    do_req(1, 8'h80, 8'h80, 1'b1);
    check("op_count_6", 32'(op_count), 32'd6);
    for (int i = 0; i < 10; i++)
      do_req(int'($urandom_range(1)), 8'($urandom), 8'($urandom), 1'($urandom));

    // Round-robin from reset with both requesters permanently valid.
    apply_reset();
    set_req(0, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
    set_req(1, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(req0_ready || req1_ready) && n < 20);
      g = req1_ready;
      check("rr_grant", 32'(g), 32'(k % 2));
      tick();
      set_req(int'(g), 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();

    // Backpressure in HOLD, and a request during the handshake cycle waits for IDLE.
    res_ready = 1'b0;
    set_req(0, 1'b1, 8'h33, 8'h44, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req0_ready && n < 20);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    set_req(0, 1'b1, 8'h33, 8'h44, 1'b0);
    set_req(1, 1'b1, 8'h10, 8'h24, 1'b1);
    cnt = op_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_sum", 32'(res_sum), 32'h077);
      check("bp_readies", {req0_ready, req1_ready}, 32'd0);
    end
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    check("hs_cycle_readies", {req0_ready, req1_ready}, 32'd0);
    tick();
    check("hs_valid", 32'(res_valid), 32'd0);
    check("hs_busy", 32'(busy), 32'd0);
    check("hs_op_count", 32'(op_count), 32'(cnt + 16'd1));
    @(negedge clk);
    check("post_hs_grant", {req0_ready, req1_ready}, 32'b01);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();

    // Reset while in CALC discards the transaction and restores the pointer.
    apply_reset();
    set_req(0, 1'b1, 8'h11, 8'h22, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req0_ready && n < 20);
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_sum", 32'(res_sum), 32'd0);
    check("mid_rst_count", 32'(op_count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    set_req(0, 1'b1, 8'h01, 8'h02, 1'b0);
    set_req(1, 1'b1, 8'h03, 8'h04, 1'b0);
    @(negedge clk);
    check("mid_rst_ptr", {req0_ready, req1_ready}, 32'b10);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();

    // Saturation: preload just below the ceiling.
    dut.op_count_q = 16'hFFFE;
    do_req(0, 8'h12, 8'h34, 1'b0);
    check("sat_reach", 32'(op_count), 32'hFFFF);
    do_req(1, 8'h56, 8'h78, 1'b1);
    check("sat_hold", 32'(op_count), 32'hFFFF);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
